se_sram_burst_ctl: RTL and testbench

SE_SRAM_BURST_CTL -- requirements
Module: se_sram_burst_ctl

---
 rtl/se_sram_pkg.sv | 21 ++
 rtl/se_sram_rd_skid.sv | 60 ++++++
 rtl/se_sram_burst_ctl.sv | 142 ++++++++++++++
 tb/tb_se_sram_burst_ctl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_sram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : se_sram_pkg
// Purpose  : Shared widths and FSM state encoding for the SRAM burst controller.
// Revision : 1.0
// ============================================================================
package se_sram_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 8;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/se_sram_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : se_sram_rd_skid
// Purpose  : Two-entry read-return FIFO; slot0 is always the head.
// Revision : 1.0
// ============================================================================
module se_sram_rd_skid
  import se_sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              pop_ok, push_ok;
  logic [1:0]        wr_idx;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    // A simultaneous pop frees the head slot before the new byte lands
    wr_idx  = count_q - {1'b0, pop_ok};
    slot0_d = pop_ok ? slot1_q : slot0_q;
    slot1_d = slot1_q;
    if (push_ok) begin
      if (wr_idx == 2'd0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
    end
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign count     = count_q;
  assign head_data = slot0_q;

endmodule
`default_nettype wire

// File: rtl/se_sram_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : se_sram_burst_ctl
// Purpose  : Burst read/write front-end for a single-port registered SRAM.
// Revision : 1.0
// ============================================================================
module se_sram_burst_ctl
  import se_sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              sram_clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [ADDR_W-1:0] cmd_length,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  output logic              sram_write_enable,
  output logic              sram_read_not_write,
  output logic              sram_select,
  input  logic [DATA_W-1:0] sram_data_out
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              inflight_q, inflight_d;

  logic              wr_fire, rd_issue, pop, drain_done;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        occupancy, room_limit;

  se_sram_rd_skid #(
    .DATA_W(DATA_W)
  ) u_rd_skid (
    .clk      (sram_clock),
    .rst      (reset),
    .push     (inflight_q),
    .push_data(sram_data_out),
    .pop      (pop),
    .count    (fifo_count),
    .head_data(fifo_head)
  );

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    addr_d     = sram_select ? ptr_q : addr_q;
    wdata_d    = wr_fire ? wr_data : wdata_q;
    inflight_d = rd_issue;
    // Exit DRAIN as soon as the FIFO will be empty after this cycle's pop
    drain_done = !inflight_q && (fifo_count == {1'b0, pop});
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ptr_d   = cmd_address;
          cnt_d   = cmd_length;
          state_d = cmd_read ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (rd_issue) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = !reset && (state_q == ST_IDLE);
    wr_ready   = !reset && (state_q == ST_WRITE);
    busy       = !reset && (state_q != ST_IDLE);
    rd_valid   = !reset && (fifo_count != 2'd0);
    rd_data    = reset ? '0 : fifo_head;
    pop        = rd_valid && rd_ready;
    wr_fire    = wr_ready && wr_valid;
    // Buffered + in-flight + this issue must still fit after the current pop
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    room_limit = 3'd1 + {2'b00, pop};
    rd_issue   = !reset && (state_q == ST_READ) && (occupancy <= room_limit);

    sram_select         = wr_fire || rd_issue;
    sram_write_enable   = wr_fire;
    sram_read_not_write = rd_issue;
    sram_address        = reset ? '0 : (sram_select ? ptr_q : addr_q);
    sram_write_data     = reset ? '0 : (wr_fire ? wr_data : wdata_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_se_sram_burst_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_se_sram_burst_ctl
// Purpose  : Scoreboard bench for se_sram_burst_ctl with a behavioural SRAM.
// Revision : 1.0
// ============================================================================
module tb_se_sram_burst_ctl;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          sram_clock = 1'b0;
  logic          reset      = 1'b1;
  logic          cmd_valid  = 1'b0;
  logic          cmd_ready;
  logic          cmd_read   = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [AW-1:0] cmd_length  = '0;
  logic          wr_valid   = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data    = '0;
  logic          rd_valid;
  logic          rd_ready   = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_write_data;
  logic          sram_write_enable;
  logic          sram_read_not_write;
  logic          sram_select;
  logic [DW-1:0] sram_data_out = '0;

  se_sram_burst_ctl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .sram_clock         (sram_clock),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_read           (cmd_read),
    .cmd_address        (cmd_address),
    .cmd_length         (cmd_length),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .wr_data            (wr_data),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .rd_data            (rd_data),
    .busy               (busy),
    .sram_address       (sram_address),
    .sram_write_data    (sram_write_data),
    .sram_write_enable  (sram_write_enable),
    .sram_read_not_write(sram_read_not_write),
    .sram_select        (sram_select),
    .sram_data_out      (sram_data_out)
  );

  always #5 sram_clock = ~sram_clock;

  int cyc = 0;
  always @(posedge sram_clock) cyc <= cyc + 1;

  // Unwritten locations read back a fixed address-derived pattern
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  logic [7:0] sram_mem [65536];
  bit         sram_wr  [65536];
  always @(posedge sram_clock) begin
    if (sram_select && sram_write_enable) begin
      sram_mem[sram_address] = sram_write_data;
      sram_wr[sram_address]  = 1'b1;
    end else if (sram_select && sram_read_not_write) begin
      sram_data_out <= sram_wr[sram_address] ? sram_mem[sram_address] : init_val(sram_address);
    end
  end

  logic [7:0] ref_mem [65536];
  bit         ref_wr  [65536];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] got);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, expected no such event (cycle %0d)", name, got, cyc);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          rel;
  } exp_t;

  exp_t        exp_wr[$];
  exp_t        exp_ra[$];
  exp_t        exp_rd[$];
  int          acc_cyc  = 0;
  int          issued   = 0;
  int          popped   = 0;
  int          last_evt = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_wd   = '0;

  always @(negedge sram_clock) begin
    exp_t e;
    logic pop_now;
    if (reset) begin
      issued    = 0;
      popped    = 0;
      last_addr = '0;
      last_wd   = '0;
    end else begin
      pop_now = rd_valid && rd_ready;
      if (sram_select && sram_write_enable) begin
        check("wr_rnw_low", 32'(sram_read_not_write), 0);
        if (exp_wr.size() == 0) begin
          flag("unexpected_write", 32'(sram_address));
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(sram_address), 32'(e.a));
          check("wr_data", 32'(sram_write_data), 32'(e.d));
          if (e.rel >= 0) check("wr_cycle", 32'(cyc - acc_cyc), 32'(e.rel));
        end
        last_addr = sram_address;
        last_wd   = sram_write_data;
        last_evt  = cyc;
      end else if (sram_select && sram_read_not_write) begin
        if (exp_ra.size() == 0) begin
          flag("unexpected_read", 32'(sram_address));
        end else begin
          e = exp_ra.pop_front();
          check("rd_issue_addr", 32'(sram_address), 32'(e.a));
          if (e.rel >= 0) check("rd_issue_cycle", 32'(cyc - acc_cyc), 32'(e.rel));
        end
        check("fifo_room", 32'((issued - popped + 1 - int'(pop_now)) <= 2), 1);
        issued++;
        last_addr = sram_address;
      end else begin
        check("strobes_idle", 32'({sram_select, sram_write_enable, sram_read_not_write}), 0);
        check("addr_hold", 32'(sram_address), 32'(last_addr));
        check("wdata_hold", 32'(sram_write_data), 32'(last_wd));
      end
      if (pop_now) begin
        if (exp_rd.size() == 0) begin
          flag("unexpected_rd_data", 32'(rd_data));
        end else begin
          e = exp_rd.pop_front();
          check("rd_data", 32'(rd_data), 32'(e.d));
          if (e.rel >= 0) check("rd_valid_cycle", 32'(cyc - acc_cyc), 32'(e.rel));
        end
        popped++;
        last_evt = cyc;
      end
    end
  end

  // One burst: queue the expected traffic, offer the command, then run the
  // data side until busy drops. abort_at >= 0 pulses reset in that cycle.
  task automatic run_burst(input bit rd, input logic [15:0] addr, input logic [15:0] len,
                           input int wv_mode, input int rdy_mode, input logic [7:0] base,
                           input bit pat_data, input int abort_at);
    logic [7:0]  wq[$];
    logic [15:0] a;
    logic [7:0]  d;
    exp_t        e;
    bit          acc, done, aborted;
    int          k, bound;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 16'(i);
      if (!rd) begin
        d = pat_data ? base + 8'(i) : 8'($urandom);
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
        wq.push_back(d);
        e.a = a; e.d = d; e.rel = (wv_mode == 0) ? 1 + i : -1;
        exp_wr.push_back(e);
      end else begin
        e.a = a; e.d = 8'h00; e.rel = (rdy_mode == 0) ? 1 + i : -1;
        exp_ra.push_back(e);
        e.d = ref_wr[a] ? ref_mem[a] : init_val(a);
        e.rel = (rdy_mode == 0) ? 3 + i : -1;
        exp_rd.push_back(e);
      end
    end
    @(posedge sram_clock); #1;
    cmd_valid   = 1'b1;
    cmd_read    = rd;
    cmd_address = addr;
    cmd_length  = len;
    wr_valid    = 1'b0;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) begin
      @(negedge sram_clock);
      if (cmd_ready) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end else begin
        @(posedge sram_clock); #1;
      end
    end
    if (!acc) begin
      flag("cmd_not_accepted", 32'(busy));
      cmd_valid = 1'b0;
      exp_wr.delete(); exp_ra.delete(); exp_rd.delete();
      return;
    end
    bound   = 8 * (int'(len) + 1) + 50;
    done    = 1'b0;
    aborted = 1'b0;
    k       = 1;
    while (!done && k < bound) begin
      @(posedge sram_clock); #1;
      cmd_valid = 1'b0;
      if (k == abort_at) reset = 1'b1;
      wr_valid = (wv_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data  = (wq.size() != 0) ? wq[0] : 8'($urandom);
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge sram_clock);
      if (reset) begin
        check("abort_select", 32'(sram_select), 0);
        check("abort_rd_valid", 32'(rd_valid), 0);
        exp_wr.delete(); exp_ra.delete(); exp_rd.delete(); wq.delete();
        @(posedge sram_clock); #1;
        reset = 1'b0;
        @(negedge sram_clock);
        check("post_abort_rd_valid", 32'(rd_valid), 0);
        check("post_abort_cmd_ready", 32'(cmd_ready), 1);
        check("post_abort_busy", 32'(busy), 0);
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        if (wr_valid && wr_ready && wq.size() != 0) void'(wq.pop_front());
        if (!busy) done = 1'b1;
      end
      k++;
    end
    wr_valid = 1'b0;
    if (!done) begin
      flag("burst_timeout", 32'(k));
      exp_wr.delete(); exp_ra.delete(); exp_rd.delete();
    end else if (!aborted) begin
      check("busy_fall", 32'(cyc), 32'(last_evt + 1));
      check("wr_left", 32'(exp_wr.size()), 0);
      check("rd_issue_left", 32'(exp_ra.size()), 0);
      check("rd_data_left", 32'(exp_rd.size()), 0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    for (int i = 0; i < 3; i++) begin
      @(negedge sram_clock);
      check("reset_select", 32'(sram_select), 0);
    end
    @(posedge sram_clock); #1;
    reset = 1'b0;
    @(negedge sram_clock);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_sram_address", 32'(sram_address), 0);
    check("rst_sram_wdata", 32'(sram_write_data), 0);
    check("rst_strobes", 32'({sram_select, sram_write_enable, sram_read_not_write}), 0);

    run_burst(1'b0, 16'h0010, 16'd3, 0, 0, 8'hA0, 1'b1, -1);
    run_burst(1'b1, 16'h0010, 16'd3, 0, 0, 8'h00, 1'b0, -1);
    run_burst(1'b1, 16'h0100, 16'd7, 1, 1, 8'h00, 1'b0, -1);
    run_burst(1'b0, 16'hFFFE, 16'd2, 0, 0, 8'h30, 1'b1, -1);
    run_burst(1'b1, 16'hFFFE, 16'd2, 1, 0, 8'h00, 1'b0, -1);

    for (int i = 0; i < 3; i++) begin
      @(posedge sram_clock); #1;
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      @(negedge sram_clock);
      check("idle_wr_ready", 32'(wr_ready), 0);
    end
    @(posedge sram_clock); #1;
    wr_valid = 1'b0;

    run_burst(1'b1, 16'h0200, 16'd15, 0, 0, 8'h00, 1'b0, 5);
    run_burst(1'b1, 16'h0011, 16'd0, 1, 0, 8'h00, 1'b0, -1);
    run_burst(1'b0, 16'h0020, 16'd0, 1, 0, 8'h00, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       ra = 16'hFFF0 + 16'($urandom_range(0, 15));
        1:       ra = 16'h0400 + 16'($urandom_range(0, 63));
        default: ra = 16'($urandom);
      endcase
      run_burst(1'($urandom_range(0, 1)), ra, 16'($urandom_range(0, 20)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                8'h00, 1'b0, -1);
    end

    repeat (3) @(posedge sram_clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
